axil_wr_router: RTL and testbench
=================================

# axil_wr_router

Registered AXI4-Lite write-path router. One master port fans out to `NUMBER_SLAVE` slave ports. It decodes the write address, locks a route for the whole transaction and sequences AW, W and B through a state machine. Unmapped addresses get a local DECERR response. It sits in the interconnect between the master-side arbiter output and the slave ports, and replaces the purely combinational grant-based response mux with a transaction-locked, decode-aware path.

## Interface
Parameters:
- `NUMBER_SLAVE`, 8: number of slave ports, ≥1.
- `AXI_DATA_WIDTH`, 32: data width, 32 or 64.
- `AXI_ADDR_WIDTH`, 32: address width.
- `SLAVE_SEL_LSB`, 16: slave region size is 2^SLAVE_SEL_LSB bytes. Slave index is `awaddr[AXI_ADDR_WIDTH-1:SLAVE_SEL_LSB]`.
- `TIMEOUT_CYCLES`, 256: watchdog limit, ≥2. Used only with `AXIL_WR_TIMEOUT_EN`.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `m_axil_awaddr`  in  AXI_ADDR_WIDTH  master write address.
- `m_axil_awvalid` / `m_axil_awready`  in / out  1  master AW handshake.
- `m_axil_wdata`  in  AXI_DATA_WIDTH  master write data.
- `m_axil_wstrb`  in  AXI_DATA_WIDTH/8  master write strobes.
- `m_axil_wvalid` / `m_axil_wready`  in / out  1  master W handshake.
- `m_axil_bresp`  out  2  master write response.
- `m_axil_bvalid` / `m_axil_bready`  out / in  1  master B handshake.
- `s_axil_awaddr`  out  AXI_ADDR_WIDTH  registered address, broadcast to all slaves.
- `s_axil_awvalid` / `s_axil_awready`  out / in  [NUMBER_SLAVE-1:0]  per-slave AW handshake.
- `s_axil_wdata`  out  AXI_DATA_WIDTH  write data, broadcast to all slaves.
- `s_axil_wstrb`  out  AXI_DATA_WIDTH/8  write strobes, broadcast to all slaves.
- `s_axil_wvalid` / `s_axil_wready`  out / in  [NUMBER_SLAVE-1:0]  per-slave W handshake.
- `s_axil_bresp`  in  2 × [NUMBER_SLAVE]  unpacked array of per-slave responses.
- `s_axil_bvalid` / `s_axil_bready`  in / out  [NUMBER_SLAVE-1:0]  per-slave B handshake.

## Operation
- States: IDLE, AW, W, B. Registers: `sel` (slave index), `local` (local-response flag), `resp` (2 bits), `awaddr_q`.
- IDLE:
  - `m_axil_awready`=1.
  - On `m_axil_awvalid`: capture the address into `awaddr_q` and compute `sel`.
  - If the index is < NUMBER_SLAVE: `local`=0, go to AW.
  - Otherwise: `local`=1, `resp`=2'b11, go to W.
- AW:
  - `s_axil_awvalid[sel]`=1; all other slaves' awvalid stay 0.
  - On `s_axil_awready[sel]`, go to W.
- W, `local`=0:
  - `s_axil_wvalid[sel]`=`m_axil_wvalid` and `m_axil_wready`=`s_axil_wready[sel]`, both combinational.
  - On the handshake, go to B.
- W, `local`=1:
  - `m_axil_wready`=1; data is sunk.
  - On `m_axil_wvalid`, go to B.
- B, `local`=0:
  - `m_axil_bvalid`=`s_axil_bvalid[sel]`, `m_axil_bresp`=`s_axil_bresp[sel]`, `s_axil_bready[sel]`=`m_axil_bready`.
  - On the handshake, go to IDLE.
- B, `local`=1:
  - `m_axil_bvalid`=1, `m_axil_bresp`=`resp`.
  - On `m_axil_bready`, go to IDLE.
- Only one transaction is in flight. `m_axil_awready`=0 outside IDLE.
- A W beat arriving before the AW handshake stalls: `m_axil_wready`=0 until state W.
- Non-selected slave valid/ready outputs are always 0. Slave bvalid/wready seen in the wrong state are ignored.

## Timing
- Reset, asynchronous and taking effect immediately:
  - state=IDLE, `sel`=0, `local`=0, `resp`=0, `awaddr_q`=0.
  - All `s_axil_*valid`/`s_axil_bready`=0.
  - `m_axil_bvalid`=0, `m_axil_bresp`=0, `m_axil_wready`=0, `m_axil_awready`=0 while `aresetn` is low.
- Reset asserted mid-transaction abandons it. There is no response to the master and no completion to the slave.
- Minimum mapped transaction, with zero-wait slaves and a master holding W and bready high: AW accept in cycle 0, slave AW in cycle 1, W in cycle 2, B in cycle 3. Four cycles, back-to-back throughput one transaction per 4 cycles.
- Minimum local (DECERR) transaction: 3 cycles.
- Outputs in AW and in local W/B states come from registers. Pass-through W/B paths are combinational through the `sel` mux.

## Configuration
- `AXIL_WR_TIMEOUT_EN` defined:
  - A counter clears on every state entry and increments each cycle spent in AW, W (`local`=0) or B (`local`=0).
  - It expires when it reaches TIMEOUT_CYCLES-1 in a cycle where the awaited slave handshake has not occurred.
  - In AW: drop `s_axil_awvalid`, set `local`=1, `resp`=2'b10, go to W.
  - In W: set `local`=1, `resp`=2'b10, stay in W; the sinking path then completes the W handshake.
  - In B: drop `s_axil_bready`, go to B with `local`=1, `resp`=2'b10.
  - The counter does not run while the master itself stalls: in W only when `m_axil_wvalid`=1, in B only when `m_axil_bready`=1.
- `AXIL_WR_TIMEOUT_EN` not defined: no counter exists, and the block waits indefinitely on the slave.

## Test plan
- Write to address 0x0002_0010 with NUMBER_SLAVE=8 and SLAVE_SEL_LSB=16 -> only `s_axil_awvalid[2]` asserts, with `s_axil_awaddr`=0x0002_0010; data and strobes pass to slave 2; bresp 2'b00 returns in cycle 3.
- Write to address 0x0009_0000 -> no slave valid asserts; data is sunk; `m_axil_bresp`=2'b11 with bvalid in cycle 2.
- Slave 5 holds bvalid 4 cycles while the master holds bready low 3 extra cycles -> bvalid/bresp stay stable; a second AW is not accepted until the B handshake.
- `aresetn` pulled low during state W -> all outputs 0 within the same cycle; after release, the next write to slave 1 completes normally.
- With `AXIL_WR_TIMEOUT_EN` and TIMEOUT_CYCLES=16, slave 3 never raises awready -> `s_axil_awvalid[3]` drops after 16 cycles; W is sunk; `m_axil_bresp`=2'b10.
- W asserted 5 cycles before AW -> `m_axil_wready` stays 0 until state W; the transaction completes with correct data at the slave.

Source files
------------

// File: rtl/axil_wr_router.sv
// Transaction-locked AXI4-Lite write router: one master fanned out to NUMBER_SLAVE slaves, local DECERR for unmapped space.
// Optional slave watchdog enabled by defining AXIL_WR_TIMEOUT_EN.
module axil_wr_router #(
  parameter int NUMBER_SLAVE   = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int SLAVE_SEL_LSB  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
  input  logic                          m_axil_awvalid,
  output logic                          m_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  input  logic                          m_axil_wvalid,
  output logic                          m_axil_wready,
  output logic [1:0]                    m_axil_bresp,
  output logic                          m_axil_bvalid,
  input  logic                          m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  output logic [NUMBER_SLAVE-1:0]       s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  output logic [NUMBER_SLAVE-1:0]       s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]       s_axil_wready,
  input  logic [1:0]                    s_axil_bresp [NUMBER_SLAVE],
  input  logic [NUMBER_SLAVE-1:0]       s_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]       s_axil_bready
);

  localparam int SELW = (NUMBER_SLAVE > 1) ? $clog2(NUMBER_SLAVE) : 1;
  localparam int IDXW = AXI_ADDR_WIDTH - SLAVE_SEL_LSB;

  if (NUMBER_SLAVE < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_wr_router: NUMBER_SLAVE must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t                    state, state_next;
  logic [SELW-1:0]           sel;
  logic                      local_rsp;
  logic [1:0]                resp;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;

  logic                      load;
  logic                      timeout;
  logic                      expire;

  logic [IDXW-1:0]           idx;
  logic [31:0]               idx_ext;
  logic                      in_range;

  logic [NUMBER_SLAVE-1:0]   sel_onehot;
  logic                      sel_awready;
  logic                      sel_wready;
  logic                      sel_bvalid;
  logic [1:0]                sel_bresp;

  assign idx      = m_axil_awaddr[AXI_ADDR_WIDTH-1:SLAVE_SEL_LSB];
  assign idx_ext  = 32'(idx);
  assign in_range = idx_ext < 32'(NUMBER_SLAVE);

  assign s_axil_awaddr = awaddr_q;
  assign s_axil_wdata  = m_axil_wdata;
  assign s_axil_wstrb  = m_axil_wstrb;

  // Loop-compare decode keeps non-power-of-two slave counts free of out-of-range indexing.
  always_comb begin
    sel_onehot  = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = 2'b00;
    for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
      if (sel == SELW'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_awready   = s_axil_awready[i];
        sel_wready    = s_axil_wready[i];
        sel_bvalid    = s_axil_bvalid[i];
        sel_bresp     = s_axil_bresp[i];
      end
    end
  end

  always_comb begin
    state_next     = state;
    load           = 1'b0;
    timeout        = 1'b0;
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bvalid  = 1'b0;
    m_axil_bresp   = 2'b00;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_bready  = '0;
    case (state)
      ST_IDLE: begin
        m_axil_awready = aresetn;
        if (m_axil_awvalid) begin
          load       = 1'b1;
          state_next = in_range ? ST_AW : ST_W;
        end
      end
      ST_AW: begin
        s_axil_awvalid = sel_onehot;
        if (sel_awready) begin
          state_next = ST_W;
        end else if (expire) begin
          timeout    = 1'b1;
          state_next = ST_W;
        end
      end
      ST_W: begin
        if (local_rsp) begin
          m_axil_wready = 1'b1;
          if (m_axil_wvalid) state_next = ST_B;
        end else begin
          s_axil_wvalid = sel_onehot & {NUMBER_SLAVE{m_axil_wvalid}};
          m_axil_wready = sel_wready;
          if (m_axil_wvalid && sel_wready) state_next = ST_B;
          else if (expire) timeout = 1'b1;
        end
      end
      ST_B: begin
        if (local_rsp) begin
          m_axil_bvalid = 1'b1;
          m_axil_bresp  = resp;
          if (m_axil_bready) state_next = ST_IDLE;
        end else begin
          m_axil_bvalid = sel_bvalid;
          m_axil_bresp  = sel_bresp;
          s_axil_bready = sel_onehot & {NUMBER_SLAVE{m_axil_bready}};
          if (sel_bvalid && m_axil_bready) state_next = ST_IDLE;
          else if (expire) timeout = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      sel       <= '0;
      local_rsp <= 1'b0;
      resp      <= 2'b00;
      awaddr_q  <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        awaddr_q  <= m_axil_awaddr;
        sel       <= SELW'(idx);
        local_rsp <= !in_range;
        resp      <= in_range ? 2'b00 : 2'b11;
      end else if (timeout) begin
        local_rsp <= 1'b1;
        resp      <= 2'b10;
      end
    end
  end

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);

  logic [CNTW-1:0] cnt;
  logic            count_en;
  logic            slave_hs;

  // Counting only while the master is ready means a stalling master never triggers the watchdog.
  always_comb begin
    count_en = 1'b0;
    slave_hs = 1'b0;
    case (state)
      ST_AW: begin
        count_en = 1'b1;
        slave_hs = sel_awready;
      end
      ST_W: begin
        count_en = !local_rsp && m_axil_wvalid;
        slave_hs = sel_wready;
      end
      ST_B: begin
        count_en = !local_rsp && m_axil_bready;
        slave_hs = sel_bvalid;
      end
      default: ;
    endcase
  end

  assign expire = count_en && !slave_hs && (cnt == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (count_en) cnt <= cnt + CNTW'(1);
  end
`else
  assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_axil_wr_router.sv
// Directed bench for axil_wr_router: mapped, DECERR, B backpressure, mid-transaction reset, early W, optional watchdog.
module tb_axil_wr_router;

  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [AW-1:0]   m_awaddr;
  logic            m_awvalid, m_awready;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wvalid, m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;
  logic [AW-1:0]   s_awaddr;
  logic [NS-1:0]   s_awvalid, s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [NS-1:0]   s_wvalid, s_wready;
  logic [1:0]      s_bresp [NS];
  logic [NS-1:0]   s_bvalid, s_bready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axil_wr_router #(
    .NUMBER_SLAVE  (NS),
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .SLAVE_SEL_LSB (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .m_axil_awaddr (m_awaddr),
    .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready),
    .m_axil_wdata  (m_wdata),
    .m_axil_wstrb  (m_wstrb),
    .m_axil_wvalid (m_wvalid),
    .m_axil_wready (m_wready),
    .m_axil_bresp  (m_bresp),
    .m_axil_bvalid (m_bvalid),
    .m_axil_bready (m_bready),
    .s_axil_awaddr (s_awaddr),
    .s_axil_awvalid(s_awvalid),
    .s_axil_awready(s_awready),
    .s_axil_wdata  (s_wdata),
    .s_axil_wstrb  (s_wstrb),
    .s_axil_wvalid (s_wvalid),
    .s_axil_wready (s_wready),
    .s_axil_bresp  (s_bresp),
    .s_axil_bvalid (s_bvalid),
    .s_axil_bready (s_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; checks follow #1 later, well clear of either edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn   = 1'b0;
    m_awaddr  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '1;
    s_wready  = '1;
    s_bvalid  = '1;
    for (int i = 0; i < NS; i++) s_bresp[i] = 2'b11;
    s_bresp[1] = 2'b00;
    s_bresp[2] = 2'b00;
    s_bresp[3] = 2'b00;
    s_bresp[5] = 2'b01;

    m_awvalid = 1'b1;
    #12;
    check("rst_awready", 64'(m_awready), 64'd0);
    check("rst_bvalid", 64'(m_bvalid), 64'd0);
    check("rst_awvalid", 64'(s_awvalid), 64'd0);
    check("rst_awaddr", 64'(s_awaddr), 64'd0);
    m_awvalid = 1'b0;
    #3 aresetn = 1'b1;
    tick();

    // Mapped write to slave 2, zero-wait slave, 4 cycles.
    m_awaddr = 32'h0002_0010; m_awvalid = 1'b1;
    m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wvalid = 1'b1; m_bready = 1'b1;
    #1;
    check("t1_c0_awready", 64'(m_awready), 64'd1);
    check("t1_c0_wready", 64'(m_wready), 64'd0);
    check("t1_c0_s_awvalid", 64'(s_awvalid), 64'd0);
    tick(); m_awvalid = 1'b0; #1;
    check("t1_c1_s_awvalid", 64'(s_awvalid), 64'h04);
    check("t1_c1_s_awaddr", 64'(s_awaddr), 64'h0002_0010);
    check("t1_c1_wready", 64'(m_wready), 64'd0);
    check("t1_c1_awready", 64'(m_awready), 64'd0);
    tick(); #1;
    check("t1_c2_s_wvalid", 64'(s_wvalid), 64'h04);
    check("t1_c2_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("t1_c2_s_wstrb", 64'(s_wstrb), 64'hF);
    check("t1_c2_wready", 64'(m_wready), 64'd1);
    tick(); #1;
    check("t1_c3_bvalid", 64'(m_bvalid), 64'd1);
    check("t1_c3_bresp", 64'(m_bresp), 64'd0);
    check("t1_c3_s_bready", 64'(s_bready), 64'h04);
    tick(); #1;
    check("t1_c4_awready", 64'(m_awready), 64'd1);
    check("t1_c4_bvalid", 64'(m_bvalid), 64'd0);

    // Unmapped address: local DECERR in 3 cycles.
    m_awaddr = 32'h0009_0000; m_awvalid = 1'b1;
    tick(); m_awvalid = 1'b0; #1;
    check("t2_c1_wready", 64'(m_wready), 64'd1);
    check("t2_c1_s_wvalid", 64'(s_wvalid), 64'd0);
    check("t2_c1_s_awvalid", 64'(s_awvalid), 64'd0);
    tick(); #1;
    check("t2_c2_bvalid", 64'(m_bvalid), 64'd1);
    check("t2_c2_bresp", 64'(m_bresp), 64'd3);
    check("t2_c2_s_bready", 64'(s_bready), 64'd0);
    tick(); #1;
    check("t2_c3_awready", 64'(m_awready), 64'd1);

    // Slave 5 response held while the master stalls bready; a queued AW must wait.
    s_bvalid = 8'h20;
    m_awaddr = 32'h0005_0000; m_awvalid = 1'b1; m_bready = 1'b0;
    tick(); m_awvalid = 1'b0;
    tick();
    tick(); m_awaddr = 32'h0009_0000; m_awvalid = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      check("t3_stall_bvalid", 64'(m_bvalid), 64'd1);
      check("t3_stall_bresp", 64'(m_bresp), 64'd1);
      check("t3_stall_awready", 64'(m_awready), 64'd0);
      check("t3_stall_s_bready", 64'(s_bready), 64'd0);
      tick(); #1;
    end
    m_bready = 1'b1;
    #1;
    check("t3_hs_s_bready", 64'(s_bready), 64'h20);
    check("t3_hs_awready", 64'(m_awready), 64'd0);
    tick(); #1;
    check("t3_next_awready", 64'(m_awready), 64'd1);
    tick(); m_awvalid = 1'b0; tick(); #1;
    check("t3_next_bresp", 64'(m_bresp), 64'd3);
    tick();
    s_bvalid = '1;

    // Reset while in W abandons the transaction.
    m_wvalid = 1'b0;
    m_awaddr = 32'h0001_0000; m_awvalid = 1'b1;
    tick(); m_awvalid = 1'b0;
    tick(); tick();
    aresetn = 1'b0; #1;
    check("t4_rst_awready", 64'(m_awready), 64'd0);
    check("t4_rst_wready", 64'(m_wready), 64'd0);
    check("t4_rst_bvalid", 64'(m_bvalid), 64'd0);
    check("t4_rst_s_valids", 64'({s_awvalid, s_wvalid, s_bready}), 64'd0);
    check("t4_rst_s_awaddr", 64'(s_awaddr), 64'd0);
    #2 aresetn = 1'b1;
    tick();
    m_awaddr = 32'h0001_0004; m_awvalid = 1'b1;
    m_wdata = 32'h1234_5678; m_wstrb = 4'hC; m_wvalid = 1'b1;
    tick(); m_awvalid = 1'b0; #1;
    check("t4_aw_s_awvalid", 64'(s_awvalid), 64'h02);
    tick(); #1;
    check("t4_w_s_wvalid", 64'(s_wvalid), 64'h02);
    check("t4_w_s_wdata", 64'(s_wdata), 64'h1234_5678);
    tick(); #1;
    check("t4_b_bvalid", 64'(m_bvalid), 64'd1);
    check("t4_b_bresp", 64'(m_bresp), 64'd0);
    tick();

    // W presented 5 cycles before AW stalls until state W.
    m_wdata = 32'hCAFE_F00D; m_wstrb = 4'h3; m_wvalid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t6_early_wready", 64'(m_wready), 64'd0);
      tick(); #1;
    end
    m_awaddr = 32'h0003_0000; m_awvalid = 1'b1; #1;
    check("t6_c0_wready", 64'(m_wready), 64'd0);
    tick(); m_awvalid = 1'b0; #1;
    check("t6_c1_wready", 64'(m_wready), 64'd0);
    tick(); #1;
    check("t6_c2_wready", 64'(m_wready), 64'd1);
    check("t6_c2_s_wvalid", 64'(s_wvalid), 64'h08);
    check("t6_c2_s_wdata", 64'(s_wdata), 64'hCAFE_F00D);
    check("t6_c2_s_wstrb", 64'(s_wstrb), 64'h3);
    tick(); #1;
    check("t6_c3_bvalid", 64'(m_bvalid), 64'd1);
    tick();

`ifdef AXIL_WR_TIMEOUT_EN
    // Slave 3 never accepts AW: watchdog drops awvalid after 16 cycles and answers SLVERR.
    s_awready = '0;
    m_awaddr = 32'h0003_0000; m_awvalid = 1'b1;
    tick(); m_awvalid = 1'b0; #1;
    for (int k = 0; k < 16; k++) begin
      check("t5_awvalid_held", 64'(s_awvalid), 64'h08);
      tick(); #1;
    end
    check("t5_awvalid_dropped", 64'(s_awvalid), 64'd0);
    check("t5_w_sunk_wready", 64'(m_wready), 64'd1);
    check("t5_w_s_wvalid", 64'(s_wvalid), 64'd0);
    tick(); #1;
    check("t5_bvalid", 64'(m_bvalid), 64'd1);
    check("t5_bresp", 64'(m_bresp), 64'd2);
    tick();
    s_awready = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
